rhythm_seq: RTL

- Parametrised beat/machine-cycle timing generator for the model computer control unit; successor of the fixed 8-beat ring counter.
- Produces one-hot beat signals T and one-hot machine-cycle signals M.
- Adds run/stop control, a programmable number of beats per machine cycle, early cycle termination and single-step.
- Feeds the microoperation decoder, which gates control signals with T[i] & M[j].

---
 rtl/rhythm_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rhythm_seq.sv
// rhythm_seq: beat / machine-cycle timing generator for the control unit.
// T is a one-hot beat ring of programmable length. M is a one-hot machine-cycle
// ring that advances each time the beat ring wraps. The block has run/stop
// control and early cycle termination through the last input.
// Optional single-step support is enabled with `define RHYTHM_SINGLE_STEP_EN.
module rhythm_seq #(
    parameter  int T_WIDTH = 8,
    parameter  int M_WIDTH = 4,
    localparam int LW      = $clog2(T_WIDTH + 1)
) (
    input  logic               clk,
    input  logic               CLEAR,
    input  logic               start,
    input  logic               stop,
    input  logic [LW-1:0]      len,
    input  logic               last,
    input  logic               step,
    output logic [T_WIDTH-1:0] T,
    output logic [LW-1:0]      T_idx,
    output logic [M_WIDTH-1:0] M,
    output logic               cyc_end,
    output logic               running
);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               running_reg;
    logic [T_WIDTH-1:0] t_reg;
    logic [LW-1:0]      t_idx_reg;
    logic [M_WIDTH-1:0] m_reg;
    logic [LW-1:0]      len_reg;

    logic [T_WIDTH-1:0] t_rot;
    logic [M_WIDTH-1:0] m_rot;
    logic [LW-1:0]      len_san;
    logic               wrap;
    logic               advance;
    logic               step_adv;

    // Left rotations of the one-hot rings. Written per bit so that a 1-wide M
    // ring simply maps onto itself.
    genvar gi;
    generate
        for (gi = 0; gi < T_WIDTH; gi++) begin : g_t_rot
            assign t_rot[gi] = t_reg[(gi + T_WIDTH - 1) % T_WIDTH];
        end
        for (gi = 0; gi < M_WIDTH; gi++) begin : g_m_rot
            assign m_rot[gi] = m_reg[(gi + M_WIDTH - 1) % M_WIDTH];
        end
    endgenerate

    // A step advances one beat only while stopped, and start takes priority.
`ifdef RHYTHM_SINGLE_STEP_EN
    assign step_adv = (state_reg == ST_STOPPED) && step && !start;
`else
    logic unused_step;
    assign unused_step = step;
    assign step_adv    = 1'b0;
`endif

    // A zero or out-of-range length means a full-width machine cycle.
    assign len_san = ((len == '0) || (len > LW'(T_WIDTH))) ? LW'(T_WIDTH) : len;

    // Mealy wrap: the final beat of the programmed length, or an early termination.
    assign wrap = (t_idx_reg == (len_reg - LW'(1))) || last;

    // Decide whether to advance this cycle and which run/stop state to take next.
    always_comb begin
        advance    = (state_reg == ST_RUN) || (state_reg == ST_STOPPING) || step_adv;
        state_next = state_reg;
        case (state_reg)
            ST_STOPPED: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = wrap ? ST_STOPPED : ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (start) begin
                    state_next = ST_RUN;
                end else if (wrap) begin
                    state_next = ST_STOPPED;
                end
            end
            default: begin
                advance    = 1'b0;
                state_next = ST_STOPPED;
            end
        endcase
    end

    // Sequencer registers. A wrap restarts the beat ring, rotates M and loads the next length.
    always_ff @(posedge clk) begin
        if (CLEAR) begin
            state_reg   <= ST_STOPPED;
            running_reg <= 1'b0;
            t_reg       <= T_WIDTH'(1);
            t_idx_reg   <= '0;
            m_reg       <= M_WIDTH'(1);
            len_reg     <= LW'(T_WIDTH);
        end else begin
            state_reg   <= state_next;
            running_reg <= (state_next != ST_STOPPED);
            if (advance) begin
                if (wrap) begin
                    t_reg     <= T_WIDTH'(1);
                    t_idx_reg <= '0;
                    m_reg     <= m_rot;
                    len_reg   <= len_san;
                end else begin
                    t_reg     <= t_rot;
                    t_idx_reg <= t_idx_reg + LW'(1);
                end
            end
        end
    end

    assign T       = t_reg;
    assign T_idx   = t_idx_reg;
    assign M       = m_reg;
    assign cyc_end = wrap;
    assign running = running_reg;

endmodule
